// File: rtl/drum_sequencer.sv
// drum_sequencer: 16-step one-bit snare pattern player feeding the APU snare voice.
// Steps are timed in video frames (frame_end strobe); each set step, and each
// rising edge of the synchronised manual button, emits a TRIG_FRAMES-long pulse.
//
// Optional feature: define DRUM_SWING_EN to lengthen even steps and shorten odd
// steps by SWING frames (bar length unchanged).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_end      one-cycle strobe per video frame
//   start, stop    one-cycle playback controls (stop wins)
//   pattern_in     new pattern, bit i = hit on step i
//   pattern_load   one-cycle strobe capturing pattern_in
//   button         asynchronous manual snare button
//   snare_trigger  registered trigger to the APU snare voice
//   step_index     current step, zero-extended to 4 bits
//   bar_start      one-cycle pulse when step 0 begins
//   running        high while playing
module drum_sequencer #(
  parameter int unsigned STEPS           = 16,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned TRIG_FRAMES     = 2,
  parameter int unsigned SWING           = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_end,
  input  logic             start,
  input  logic             stop,
  input  logic [STEPS-1:0] pattern_in,
  input  logic             pattern_load,
  input  logic             button,
  output logic             snare_trigger,
  output logic [3:0]       step_index,
  output logic             bar_start,
  output logic             running
);

  // Frame counter sized for the longest possible (swung) step.
  localparam int unsigned CNT_W  = $clog2(FRAMES_PER_STEP + SWING + 1);
  localparam int unsigned TRIG_W = $clog2(TRIG_FRAMES + 1);
  localparam logic [3:0]  LAST_STEP = 4'(STEPS - 1);

  typedef enum logic [1:0] {S_STOPPED, S_ARMED, S_RUNNING} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_next;
  logic [3:0]         step_next;
  logic [TRIG_W-1:0]  trig_cnt;
  logic [STEPS-1:0]   active_pat, shadow_pat;
  logic               pending;
  logic               btn_meta, btn_sync, btn_prev;

  logic               btn_edge_c;
  logic               wrap_c;
  logic               copy_c;
  logic               fire_c;
  logic               bar_c;
  logic [CNT_W-1:0]   last_frame_c;
  logic [STEPS-1:0]   eff_pat_c;
  logic [15:0]        pat_ext_c;

  // Index of the final frame of the current step.
`ifdef DRUM_SWING_EN
  assign last_frame_c = step_index[0] ? CNT_W'(FRAMES_PER_STEP - SWING - 1)
                                      : CNT_W'(FRAMES_PER_STEP + SWING - 1);
`else
  assign last_frame_c = CNT_W'(FRAMES_PER_STEP - 1);
`endif

  assign btn_edge_c = btn_sync & ~btn_prev;

  // Bar wrap: last frame of the last step while playing.
  assign wrap_c = (state == S_RUNNING) && frame_end && !stop &&
                  (frame_cnt == last_frame_c) && (step_index == LAST_STEP);

  // A pending load lands immediately when idle, otherwise only at the bar wrap;
  // the fire decision on that edge must already see the new pattern.
  assign copy_c    = pending && ((state != S_RUNNING) || wrap_c);
  assign eff_pat_c = copy_c ? shadow_pat : active_pat;
  assign pat_ext_c = 16'(eff_pat_c);

  // Next-state, step/frame advance and fire decision.
  always_comb begin
    state_next     = state;
    step_next      = step_index;
    frame_cnt_next = frame_cnt;
    fire_c         = 1'b0;
    bar_c          = 1'b0;
    if (stop) begin
      state_next     = S_STOPPED;
      step_next      = 4'd0;
      frame_cnt_next = '0;
    end else begin
      case (state)
        S_STOPPED: begin
          if (start) state_next = S_ARMED;
        end
        S_ARMED: begin
          if (frame_end) begin
            state_next     = S_RUNNING;
            step_next      = 4'd0;
            frame_cnt_next = '0;
            bar_c          = 1'b1;
            fire_c         = pat_ext_c[0];
          end
        end
        S_RUNNING: begin
          if (frame_end) begin
            if (frame_cnt == last_frame_c) begin
              frame_cnt_next = '0;
              if (step_index == LAST_STEP) begin
                step_next = 4'd0;
                bar_c     = 1'b1;
              end else begin
                step_next = 4'(step_index + 4'd1);
              end
              fire_c = pat_ext_c[step_next];
            end else begin
              frame_cnt_next = CNT_W'(frame_cnt + CNT_W'(1));
            end
          end
        end
        default: state_next = S_STOPPED;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_STOPPED;
      step_index    <= 4'd0;
      frame_cnt     <= '0;
      trig_cnt      <= '0;
      snare_trigger <= 1'b0;
      bar_start     <= 1'b0;
      running       <= 1'b0;
    end else begin
      state      <= state_next;
      step_index <= step_next;
      frame_cnt  <= frame_cnt_next;
      // A coincident step fire and button edge produce a single load.
      if (fire_c || btn_edge_c) begin
        trig_cnt <= TRIG_W'(TRIG_FRAMES);
      end else if (stop) begin
        trig_cnt <= '0;
      end else if (frame_end && (trig_cnt != '0)) begin
        trig_cnt <= TRIG_W'(trig_cnt - TRIG_W'(1));
      end
      snare_trigger <= (trig_cnt != '0);
      bar_start     <= bar_c;
      running       <= (state_next == S_RUNNING);
    end
  end

  // Shadow/active pattern with deferred handover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_pat <= '0;
      shadow_pat <= '0;
      pending    <= 1'b0;
    end else begin
      if (pattern_load) shadow_pat <= pattern_in;
      if (copy_c)       active_pat <= shadow_pat;
      pending <= pattern_load | (pending & ~copy_c);
    end
  end

  // Button synchroniser plus edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

endmodule
